linear_regression_prediction: RTL and testbench

Inference stage of the linear-regression datapath. It evaluates y = θ0 + θ1·x on a stream of unsigned integer samples, using model coefficients supplied by the upstream training block. It sits after the θ estimator and produces one registered prediction per accepted sample.

---
 rtl/lr_pkg.sv | 9 +
 rtl/lr_mac_sat.sv | 28 ++
 rtl/linear_regression_prediction.sv | 67 ++++++
 tb/tb_linear_regression_prediction.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lr_pkg.sv
// Shared constants for the linear-regression inference datapath.
package lr_pkg;

  localparam int LR_DATA_WIDTH = 32;

  // Saturation ceiling for a prediction of LR_DATA_WIDTH bits.
  localparam logic [LR_DATA_WIDTH-1:0] LR_MAX = '1;

endpackage : lr_pkg

// File: rtl/lr_mac_sat.sv
// Combinational y = theta0 + theta1*x with unsigned saturation to N bits.
module lr_mac_sat
  import lr_pkg::*;
#(
  parameter int N = LR_DATA_WIDTH
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] theta0,
  input  logic [N-1:0] theta1,
  output logic [N-1:0] y
);

  localparam logic [N-1:0] sat_max = '1;

  logic [2*N-1:0] prod;
  logic [2*N:0]   sum;
  logic           over;

  // Full-width product and sum so the overflow test sees every carried bit;
  // the multiply is plain '*' so synthesis can retime it.
  always_comb begin
    prod = theta1 * x;
    sum  = {1'b0, prod} + {{(N+1){1'b0}}, theta0};
    over = |sum[2*N:N];
    y    = over ? sat_max : sum[N-1:0];
  end

endmodule : lr_mac_sat

// File: rtl/linear_regression_prediction.sv
// Inference stage: registered, saturated y = theta0 + theta1*x, one per accepted sample.
module linear_regression_prediction
  import lr_pkg::*;
#(
  parameter int N = LR_DATA_WIDTH
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [N-1:0] i_samples_x_in,
  input  logic         i_samples_x_vld,
  input  logic [N-1:0] i_theta0_out,
  input  logic [N-1:0] i_theta1_out,
  input  logic         i_theta1_out_vld,
  output logic         o_predict_out_vld,
  output logic [N-1:0] o_predict_out
);

  // Valid-only stream, no ready: a sample is taken on every edge where
  // i_samples_x_vld=1 and coefficients exist (loaded earlier or arriving now);
  // o_predict_out_vld pulses for exactly one cycle per taken sample.

  logic [N-1:0] th0_q;
  logic [N-1:0] th1_q;
  logic         th_loaded;

  logic [N-1:0] th0_eff;
  logic [N-1:0] th1_eff;
  logic         accept;
  logic [N-1:0] y_next;

  // Same-cycle coefficient updates bypass the registers.
  always_comb begin
    th0_eff = i_theta1_out_vld ? i_theta0_out : th0_q;
    th1_eff = i_theta1_out_vld ? i_theta1_out : th1_q;
    accept  = i_samples_x_vld & (th_loaded | i_theta1_out_vld);
  end

  lr_mac_sat #(
    .N(N)
  ) u_mac (
    .x      (i_samples_x_in),
    .theta0 (th0_eff),
    .theta1 (th1_eff),
    .y      (y_next)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      th0_q             <= '0;
      th1_q             <= '0;
      th_loaded         <= 1'b0;
      o_predict_out_vld <= 1'b0;
      o_predict_out     <= '0;
    end else begin
      if (i_theta1_out_vld) begin
        th0_q     <= i_theta0_out;
        th1_q     <= i_theta1_out;
        th_loaded <= 1'b1;
      end
      o_predict_out_vld <= accept;
      if (accept) begin
        o_predict_out <= y_next;
      end
    end
  end

endmodule : linear_regression_prediction

// File: tb/tb_linear_regression_prediction.sv
// Self-checking bench for linear_regression_prediction against a reference model.
module tb_linear_regression_prediction;
  import lr_pkg::*;

  localparam int W = LR_DATA_WIDTH;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] x;
  logic         x_vld;
  logic [W-1:0] t0;
  logic [W-1:0] t1;
  logic         t_vld;
  logic         p_vld;
  logic [W-1:0] p_y;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] m_th0, m_th1, m_y;
  logic         m_loaded, m_vld;

  linear_regression_prediction #(.N(W)) dut (
    .i_clock           (clk),
    .i_reset           (rst_n),
    .i_samples_x_in    (x),
    .i_samples_x_vld   (x_vld),
    .i_theta0_out      (t0),
    .i_theta1_out      (t1),
    .i_theta1_out_vld  (t_vld),
    .o_predict_out_vld (p_vld),
    .o_predict_out     (p_y)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_predict(logic [W-1:0] xv, logic [W-1:0] a0,
                                                logic [W-1:0] a1);
    longint unsigned ux, u0, u1, s;
    ux = xv;
    u0 = a0;
    u1 = a1;
    s  = u1 * ux + u0;
    if (s > 64'h0000_0000_FFFF_FFFF) return LR_MAX;
    return s[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic xv, input logic [W-1:0] xd,
                       input logic tv, input logic [W-1:0] a0, input logic [W-1:0] a1);
    rst_n = r;
    x_vld = xv;
    x     = xd;
    t_vld = tv;
    t0    = a0;
    t1    = a1;
  endtask

  // Advance the model by one edge, clock the DUT, then compare away from the edge.
  task automatic step(input string tag);
    if (!rst_n) begin
      m_th0 = '0; m_th1 = '0; m_loaded = 1'b0; m_vld = 1'b0; m_y = '0;
    end else begin
      logic [W-1:0] e0, e1;
      e0 = t_vld ? t0 : m_th0;
      e1 = t_vld ? t1 : m_th1;
      m_vld = x_vld && (m_loaded || t_vld);
      if (m_vld) m_y = ref_predict(x, e0, e1);
      if (t_vld) begin
        m_th0 = t0; m_th1 = t1; m_loaded = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, W'(p_vld), W'(m_vld));
    chk({tag, "_y"}, p_y, m_y);
  endtask

  initial begin
    m_th0 = '0; m_th1 = '0; m_y = '0; m_loaded = 1'b0; m_vld = 1'b0;

    // reset held for two edges with a sample and a coefficient strobe present
    drive(1'b0, 1'b1, 32'd55, 1'b1, 32'd9, 32'd9);
    step("rst0");
    step("rst1");
    chk("rst_y", p_y, '0);
    chk("rst_vld", W'(p_vld), '0);

    // same-cycle coefficient load and sample
    drive(1'b1, 1'b1, 32'd100, 1'b1, 32'd69403, 32'd1111);
    step("first");
    chk("first_const", p_y, 32'd180503);
    drive(1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
    step("x0");
    chk("x0_const", p_y, 32'd69403);

    // 50 back-to-back samples on stored coefficients
    for (int i = 1; i <= 50; i++) begin
      drive(1'b1, 1'b1, W'(i), 1'b0, $urandom, $urandom);
      step("stream");
      chk("stream_const", p_y, W'(69403 + 1111 * i));
    end

    // idle cycle: output holds, no strobe
    drive(1'b1, 1'b0, 32'd7, 1'b0, 32'd0, 32'd0);
    step("idle");

    // saturation
    drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'd5, 32'd2);
    step("sat1");
    chk("sat1_const", p_y, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd0);
    step("sat2");
    chk("sat2_const", p_y, 32'hFFFF_FFFF);

    // update without sample: registers only
    drive(1'b1, 1'b0, 32'd0, 1'b1, 32'd1, 32'd1);
    step("upd_only");
    drive(1'b1, 1'b1, 32'd10, 1'b0, 32'd0, 32'd0);
    step("upd_use");
    chk("upd_use_const", p_y, 32'd11);

    // reset, then sample before any load is dropped
    drive(1'b0, 1'b1, 32'd3, 1'b0, 32'd0, 32'd0);
    step("rst2");
    drive(1'b1, 1'b1, 32'd4, 1'b0, 32'd0, 32'd0);
    step("noload");
    chk("noload_vld", W'(p_vld), '0);
    drive(1'b1, 1'b1, 32'd4, 1'b1, 32'd7, 32'd3);
    step("load19");
    chk("load19_const", p_y, 32'd19);

    // mid-stream reset
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, $urandom_range(0, 1000), 1'b0, 32'd0, 32'd0);
      step("pre_mid");
    end
    drive(1'b0, 1'b1, 32'd99, 1'b0, 32'd0, 32'd0);
    step("mid_rst");
    chk("mid_rst_y", p_y, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, $urandom_range(1, 1000), 1'b0, 32'd0, 32'd0);
      step("post_mid");
      chk("post_mid_vld", W'(p_vld), '0);
    end
    drive(1'b1, 1'b1, 32'd6, 1'b1, 32'd2, 32'd5);
    step("reload");
    chk("reload_const", p_y, 32'd32);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] rx, r0, r1;
      rx = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, 70000));
      r0 = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, 70000));
      r1 = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, 70000));
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), rx,
            ($urandom_range(0, 5) == 0), r0, r1);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_linear_regression_prediction
